rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Shares the single write port of the 8-entry register file (we3/wa3/wd3) among NREQ requesters, e.g. ALU writeback, load unit and debug port.
- Grants round-robin, one write per cycle, and drives registered write signals into the register file.
- Also sequences a "clear" sweep that zeroes r1..r7 on command without a register-file reset.
- r0 is treated as read-only zero: writes to it are accepted and discarded.

Parameters:
- WIDTH, 8, data width of the register file.
- NREQ, 3, number of write requesters; legal range 2..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  3*NREQ  packed destination addresses; requester i uses bits [3i+2:3i].
- req_data  in  WIDTH*NREQ  packed write data; requester i uses bits [WIDTH*i+WIDTH-1:WIDTH*i].
- req_ready  out  NREQ  combinational grant; transfer when valid&&ready.
- clr_req  in  1  request a clear sweep of r1..r7.
- clr_done  out  1  one-cycle pulse on the final clear write.
- busy  out  1  high while in CLEAR.
- we3  out  1  register-file write enable, registered.
- wa3  out  3  register-file write address, registered.
- wd3  out  WIDTH  register-file write data, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - we3=0, wa3=0, wd3=0, clr_done=0, busy=0.
  - Round-robin pointer ptr=0, state=ARB, clear index=1.
  - req_ready=0 while rst=0.
- States: ARB, CLEAR.
- ARB:
  - If clr_req=1, go to CLEAR next cycle and assert no req_ready this cycle. clr_req has priority over all requests.
  - Otherwise scan requesters ptr, ptr+1, …, wrapping mod NREQ. The first with req_valid=1 gets req_ready=1 (one-hot, at most one bit set) and ptr becomes grant+1 mod NREQ.
  - No valid requests: req_ready=0, ptr unchanged, we3=0 next cycle.
- Accepted write:
  - Next edge registers wa3=addr and wd3=data.
  - we3=1 only if addr!=0. If addr==0, we3=0, the request still completes and ptr still advances.
  - Latency: accept at edge N, we3 visible after edge N, register file updates at edge N+1.
- CLEAR:
  - busy=1 and req_ready=0 for all requesters.
  - Seven consecutive cycles issue we3=1, wd3=0, wa3=1..7 in order.
  - clr_done=1 in the same cycle that we3/wa3=7 is driven.
  - Then return to ARB; ptr is preserved across the sweep.
  - clr_req is ignored while in CLEAR.
- Requests stay pending across CLEAR. Requesters must hold valid, addr and data stable until ready; the arbiter does not buffer them.
- Back-to-back: one write per cycle sustained. A requester gets at most one grant per NREQ cycles when all are valid.
- Reset mid-CLEAR aborts the sweep immediately. All outputs take their reset values; remaining registers are not cleared.

Optional Feature:
- Macro RF_ARB_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt (8 bits), reset to 0.
  - Increments by 1 on each accepted write with addr==0.
  - Saturates at 255.
- Undefined: port absent and no counter logic; all other behaviour identical.

Test Plan:
- Reset: hold rst=0 with req_valid=3'b111 -> req_ready=0, we3=0, wa3=0, wd3=0, busy=0. After release, first grant goes to requester 0.
- Single request: requester 1 sends addr=5, data=8'hA5 for one cycle -> req_ready=3'b010 that cycle; next cycle we3=1, wa3=5, wd3=8'hA5; then we3=0.
- Round-robin: all three hold valid with addrs 1/2/3 -> grants 0,1,2,0,… on consecutive cycles; we3 stays high with wa3 sequence 1,2,3,1.
- r0 drop: requester 2 sends addr=0, data=8'hFF -> accepted; next cycle we3=0; drop_cnt increments 0->1 when RF_ARB_DROP_CNT_EN is defined.
- Clear with pending traffic: pulse clr_req while requester 0 is valid -> req_ready=0 for 7 cycles; we3=1, wd3=0, wa3=1..7; clr_done high with wa3=7; busy high for exactly those 7 cycles; requester 0 granted on the following cycle.
- Reset mid-clear: assert rst=0 when wa3=4 -> we3, busy and clr_done drop immediately. After release the state is ARB and no further clear writes occur.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register-file write port, with an r1..r7 clear sweep.
// Optional r0-drop counter output enabled by defining RF_ARB_DROP_CNT_EN.
module rf_write_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [3*NREQ-1:0]       req_addr,
  input  logic [WIDTH*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    clr_req,
  output logic                    clr_done,
  output logic                    busy,
  output logic                    we3,
  output logic [2:0]              wa3,
  output logic [WIDTH-1:0]        wd3
`ifdef RF_ARB_DROP_CNT_EN
  ,
  output logic [7:0]              drop_cnt
`endif
);

  localparam int unsigned PW = (NREQ > 2) ? 2 : 1;

  typedef enum logic {ARB, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [2:0]       idx_q, idx_d;
  logic             we3_q, we3_d;
  logic [2:0]       wa3_q, wa3_d;
  logic [WIDTH-1:0] wd3_q, wd3_d;

  logic [NREQ-1:0]  grant;
  logic             found;
  logic [2:0]       gnt_addr;
  logic [WIDTH-1:0] gnt_data;
  logic [PW-1:0]    gnt_idx;

  // Scan starts at ptr_q; the outer index sets priority, the inner finds the requester.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    gnt_addr = '0;
    gnt_data = '0;
    gnt_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found && (j == (32'(ptr_q) + i) % NREQ) && req_valid[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          gnt_addr = req_addr[3*j +: 3];
          gnt_data = req_data[WIDTH*j +: WIDTH];
          gnt_idx  = PW'(j);
        end
      end
    end
  end

`ifdef RF_ARB_DROP_CNT_EN
  logic drop_inc;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    we3_d     = 1'b0;
    wa3_d     = wa3_q;
    wd3_d     = wd3_q;
    req_ready = '0;
`ifdef RF_ARB_DROP_CNT_EN
    drop_inc  = 1'b0;
`endif
    case (state_q)
      ARB: begin
        if (clr_req) begin
          state_d = CLEAR;
          we3_d   = 1'b1;
          wa3_d   = idx_q;
          wd3_d   = '0;
          idx_d   = idx_q + 3'd1;
        end else if (found) begin
          req_ready = grant;
          ptr_d     = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          we3_d     = (gnt_addr != 3'd0);
          wa3_d     = gnt_addr;
          wd3_d     = gnt_data;
`ifdef RF_ARB_DROP_CNT_EN
          drop_inc  = (gnt_addr == 3'd0);
`endif
        end
      end
      CLEAR: begin
        // wa3_q holds the clear address currently presented to the register file.
        if (wa3_q == 3'd7) begin
          state_d = ARB;
          idx_d   = 3'd1;
        end else begin
          we3_d = 1'b1;
          wa3_d = idx_q;
          wd3_d = '0;
          idx_d = idx_q + 3'd1;
        end
      end
      default: state_d = ARB;
    endcase
    if (!rst) req_ready = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      idx_q   <= 3'd1;
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      we3_q   <= we3_d;
      wa3_q   <= wa3_d;
      wd3_q   <= wd3_d;
    end
  end

  assign we3      = we3_q;
  assign wa3      = wa3_q;
  assign wd3      = wd3_q;
  assign busy     = (state_q == CLEAR);
  assign clr_done = busy && (wa3_q == 3'd7);

`ifdef RF_ARB_DROP_CNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
    end else if (drop_inc && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule
